// File: rtl/fetcher.sv
// Instruction-fetch stage: one AXI4-Lite-style 32-bit read per enabled pulse, with
// misaligned/bus-error reporting. Define FETCH_BUFFER_EN for a one-entry fetch buffer.
module fetcher #(
    parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enabled,
`ifdef FETCH_BUFFER_EN
    input  logic        fence_i,
`endif
    output logic        completed,
    input  logic [31:0] pc,
    output logic [31:0] pc_out,
    output logic [31:0] instr_raw,
    output logic        misaligned,
    output logic        access_fault,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic        aligned;
    logic        buf_hit;
    logic [31:0] buf_word;

    assign aligned = (pc[1:0] == 2'b00);

`ifdef FETCH_BUFFER_EN
    logic        buf_valid;
    logic [31:0] buf_tag;

    assign buf_hit = buf_valid && (pc == buf_tag);

    // fence_i wins over a fill landing in the same cycle
    always_ff @(posedge clk) begin
        if (!rstn || fence_i) begin
            buf_valid <= 1'b0;
            buf_tag   <= 32'h0;
            buf_word  <= RESET_INSTR;
        end else if (state == DATA && m_rvalid && m_rresp == 2'b00) begin
            buf_valid <= 1'b1;
            buf_tag   <= m_araddr;
            buf_word  <= m_rdata;
        end
    end
`else
    assign buf_hit  = 1'b0;
    assign buf_word = RESET_INSTR;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enabled) begin
                    state_next = (aligned && !buf_hit) ? ADDR : DONE;
                end
            end
            ADDR: begin
                if (m_arready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (m_rvalid) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign completed = (state == DONE);
    assign m_arvalid = (state == ADDR);
    assign m_rready  = (state == DATA);

    // m_araddr doubles as the latched pc of a bus fetch; results land on the DONE entry edge
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_araddr     <= 32'h0;
            pc_out       <= 32'h0;
            instr_raw    <= RESET_INSTR;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enabled) begin
                        misaligned   <= !aligned;
                        access_fault <= 1'b0;
                        if (!aligned) begin
                            pc_out    <= pc;
                            instr_raw <= RESET_INSTR;
                        end else if (buf_hit) begin
                            pc_out    <= pc;
                            instr_raw <= buf_word;
                        end else begin
                            m_araddr  <= pc;
                        end
                    end
                end
                DATA: begin
                    if (m_rvalid) begin
                        pc_out <= m_araddr;
                        if (m_rresp == 2'b00) begin
                            instr_raw <= m_rdata;
                        end else begin
                            access_fault <= 1'b1;
                            instr_raw    <= RESET_INSTR;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: directed cases then randomized fetches against
// a transaction-level model (latency, returned word, pc, fault flags, buffer hits).
`timescale 1ns/1ps
module tb_fetcher;

    localparam logic [31:0] NOP = 32'h00000013;
`ifdef FETCH_BUFFER_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        enabled;
    logic        completed;
    logic [31:0] pc;
    logic [31:0] pc_out;
    logic [31:0] instr_raw;
    logic        misaligned;
    logic        access_fault;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
`ifdef FETCH_BUFFER_EN
    logic        fence_i;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] model_pc_out;
    logic [31:0] model_instr;
    logic        model_buf_valid;
    logic [31:0] model_buf_tag;
    logic [31:0] model_buf_word;

    always #5 clk = ~clk;

    fetcher dut (
        .clk          (clk),
        .rstn         (rstn),
        .enabled      (enabled),
`ifdef FETCH_BUFFER_EN
        .fence_i      (fence_i),
`endif
        .completed    (completed),
        .pc           (pc),
        .pc_out       (pc_out),
        .instr_raw    (instr_raw),
        .misaligned   (misaligned),
        .access_fault (access_fault),
        .m_araddr     (m_araddr),
        .m_arvalid    (m_arvalid),
        .m_arready    (m_arready),
        .m_rdata      (m_rdata),
        .m_rresp      (m_rresp),
        .m_rvalid     (m_rvalid),
        .m_rready     (m_rready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic idleSlave();
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = 32'h0;
        m_rresp   = 2'b00;
    endtask

    task automatic modelReset();
        model_pc_out    = 32'h0;
        model_instr     = NOP;
        model_buf_valid = 1'b0;
        model_buf_tag   = 32'h0;
        model_buf_word  = 32'h0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_completed"}, 32'(completed), 32'd0);
        checkOutput({tag, "_arvalid"},   32'(m_arvalid), 32'd0);
        checkOutput({tag, "_rready"},    32'(m_rready), 32'd0);
        checkOutput({tag, "_misalign"},  32'(misaligned), 32'd0);
        checkOutput({tag, "_afault"},    32'(access_fault), 32'd0);
        checkOutput({tag, "_araddr"},    m_araddr, 32'h0);
        checkOutput({tag, "_pc_out"},    pc_out, 32'h0);
        checkOutput({tag, "_instr"},     instr_raw, NOP);
    endtask

    // One fetch: the bench plays the slave, injects ignored enabled pulses and
    // spurious rvalid in ADDR, and compares against the model's expected outcome.
    task automatic applyStimulus(input logic [31:0] fpc, input int ar_d, input int r_d,
                                 input logic [31:0] rd, input logic [1:0] rr);
        logic        misal, hit, bus, exp_af, done;
        logic        saw_ar, addr_ok, hold_ok, overlap_ok, flags_ok;
        logic [31:0] exp_instr, got_instr, got_pc;
        logic        got_mis, got_af;
        int          exp_lat, cycles, ar_cnt, r_cnt;

        misal = (fpc[1:0] != 2'b00);
        hit   = BUF_EN && !misal && model_buf_valid && (model_buf_tag == fpc);
        bus   = !misal && !hit;
        exp_af = 1'b0;
        if (misal) begin
            exp_lat   = 1;
            exp_instr = NOP;
        end else if (hit) begin
            exp_lat   = 1;
            exp_instr = model_buf_word;
        end else begin
            exp_lat   = 3 + ar_d + r_d;
            exp_af    = (rr != 2'b00);
            exp_instr = exp_af ? NOP : rd;
        end

        done = 1'b0; saw_ar = 1'b0; addr_ok = 1'b1; hold_ok = 1'b1;
        overlap_ok = 1'b1; flags_ok = 1'b1;
        got_instr = 32'h0; got_pc = 32'h0; got_mis = 1'b0; got_af = 1'b0;
        cycles = 0; ar_cnt = 0; r_cnt = 0;

        @(negedge clk);
        enabled = 1'b1;
        pc      = fpc;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1 && bus) flags_ok = !misaligned && !access_fault;
            if (m_arvalid) begin
                saw_ar = 1'b1;
                if (m_araddr !== fpc) addr_ok = 1'b0;
            end
            if (m_arvalid && m_rready) overlap_ok = 1'b0;
            if (completed) begin
                done      = 1'b1;
                got_instr = instr_raw;
                got_pc    = pc_out;
                got_mis   = misaligned;
                got_af    = access_fault;
            end else if (pc_out !== model_pc_out || instr_raw !== model_instr) begin
                hold_ok = 1'b0;
            end
            enabled = ($urandom_range(0, 2) == 0);
            pc      = $urandom;
            if (m_arvalid) begin
                m_arready = (ar_cnt >= ar_d);
                ar_cnt++;
            end else begin
                m_arready = 1'b0;
            end
            if (m_rready) begin
                m_rvalid = (r_cnt >= r_d);
                m_rdata  = m_rvalid ? rd : $urandom;
                m_rresp  = m_rvalid ? rr : 2'($urandom);
                r_cnt++;
            end else begin
                m_rvalid = m_arvalid && ($urandom_range(0, 1) == 1);
                m_rdata  = $urandom;
                m_rresp  = 2'($urandom);
            end
        end
        idleSlave();

        model_pc_out = fpc;
        model_instr  = exp_instr;
        if (bus && rr == 2'b00) begin
            model_buf_valid = 1'b1;
            model_buf_tag   = fpc;
            model_buf_word  = rd;
        end

        checkOutput("latency",      32'(cycles), 32'(exp_lat));
        checkOutput("instr_raw",    got_instr, exp_instr);
        checkOutput("pc_out",       got_pc, fpc);
        checkOutput("misaligned",   32'(got_mis), 32'(misal));
        checkOutput("access_fault", 32'(got_af), 32'(exp_af));
        checkOutput("bus_used",     32'(saw_ar), 32'(bus));
        checkOutput("addr_stable",  32'(addr_ok), 32'd1);
        checkOutput("outputs_held", 32'(hold_ok), 32'd1);
        checkOutput("ar_r_overlap", 32'(overlap_ok), 32'd1);
        if (bus) checkOutput("flags_cleared", 32'(flags_ok), 32'd1);

        @(negedge clk);
        checkOutput("single_pulse",   32'(completed), 32'd0);
        checkOutput("enable_ignored", 32'(m_arvalid), 32'd0);
        enabled = 1'b0;
    endtask

    // Reset while the read data phase is open: no completion, all outputs reset
    task automatic resetDuringData();
        int cycles;
        @(negedge clk);
        enabled = 1'b1;
        pc      = 32'h300;
        @(negedge clk);
        enabled = 1'b0;
        cycles  = 0;
        while (!m_rready && cycles < 10) begin
            m_arready = m_arvalid;
            @(negedge clk);
            cycles++;
        end
        checkOutput("reached_data", 32'(m_rready), 32'd1);
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = 32'hdeadbeef;
        rstn      = 1'b0;
        @(negedge clk);
        idleSlave();
        checkReset("mid_reset");
        rstn = 1'b1;
        modelReset();
        @(negedge clk);
        checkOutput("no_completed_after_reset", 32'(completed), 32'd0);
        checkOutput("idle_after_reset", 32'(m_arvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rpc, last_pc;
        int          sel;

        rstn    = 1'b0;
        enabled = 1'b0;
        pc      = 32'h0;
`ifdef FETCH_BUFFER_EN
        fence_i = 1'b0;
`endif
        idleSlave();
        modelReset();
        repeat (2) @(negedge clk);
        checkReset("por");
        rstn = 1'b1;

        applyStimulus(32'h100, 0, 0, 32'h00500093, 2'b00);
        applyStimulus(32'h104, 2, 3, 32'h00a00113, 2'b00);
        applyStimulus(32'h102, 0, 0, 32'h11111111, 2'b00);
        applyStimulus(32'h108, 0, 1, 32'h22222222, 2'b10);
        applyStimulus(32'h10c, 1, 0, 32'h33333333, 2'b00);
        resetDuringData();
        applyStimulus(32'h0, 0, 0, 32'h00000297, 2'b00);

`ifdef FETCH_BUFFER_EN
        applyStimulus(32'h200, 0, 0, 32'h44444444, 2'b00);
        applyStimulus(32'h200, 0, 0, 32'h55555555, 2'b00);
        @(negedge clk);
        fence_i = 1'b1;
        @(negedge clk);
        fence_i = 1'b0;
        model_buf_valid = 1'b0;
        applyStimulus(32'h200, 1, 1, 32'h66666666, 2'b00);
`endif

        last_pc = 32'h0;
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                rpc = ($urandom & 32'hffff_fffc) | 32'($urandom_range(1, 3));
            end else if (sel <= 2) begin
                rpc = last_pc;
            end else begin
                rpc = $urandom & 32'hffff_fffc;
            end
            applyStimulus(rpc, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                          ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            last_pc = rpc;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
